// File: rtl/bht_ctrl.sv
// ---------------------------------------------------------------------------
// bht_ctrl -- branch history table controller
//
// Owns a 2^IDX_W-entry table of 2-bit saturating predictor counters.
// The table has one access slot per cycle. The slot is shared between
// IF-stage lookups and drains of a small FIFO that buffers EX-stage branch
// outcome updates. After reset the controller sweeps every entry to
// Strongly-Not-Taken (00). It accepts no traffic until the sweep is done.
//
// Optional feature: define BHT_GSHARE_EN for gshare indexing. The table
// index is then pc[IDX_W+1:2] XOR a global history register (GHR). The GHR
// shifts in each drained outcome. Without the macro the index is purely
// bimodal and no GHR flops exist.
//
// Parameters
//   IDX_W       table index width (2^IDX_W entries, index = pc[IDX_W+1:2])
//   UPDQ_D      update FIFO depth (>= 1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   lk_valid    lookup request
//   lk_pc       lookup PC
//   lk_ready    lookup accepted when lk_valid && lk_ready
//   pred_valid  prediction valid, one cycle after an accepted lookup
//   pred_state  counter value read (11 T, 10 t, 01 n, 00 N)
//   pred_taken  pred_state[1]
//   up_valid    resolved-branch update request
//   up_pc       PC of the resolved branch
//   up_taken    actual outcome
//   up_ready    update accepted into the FIFO when up_valid && up_ready
//   init_busy   table sweep in progress
// ---------------------------------------------------------------------------
module bht_ctrl #(
    parameter int IDX_W  = 6,
    parameter int UPDQ_D = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    output logic        lk_ready,
    output logic        pred_valid,
    output logic [1:0]  pred_state,
    output logic        pred_taken,
    input  logic        up_valid,
    input  logic [31:0] up_pc,
    input  logic        up_taken,
    output logic        up_ready,
    output logic        init_busy
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int CNT_W   = $clog2(UPDQ_D + 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   init_busy_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pred_valid_q;
    logic [1:0]             pred_state_q;

    logic [1:0]             tbl_q      [ENTRIES];
    logic [IDX_W-1:0]       fifo_idx_q [UPDQ_D];
    logic                   fifo_tk_q  [UPDQ_D];

    logic                   run;
    logic                   full;
    logic                   drain;
    logic                   lookup;
    logic                   push;
    logic [IDX_W-1:0]       hist;
    logic [IDX_W-1:0]       lk_idx;
    logic [IDX_W-1:0]       dr_idx;
    logic [1:0]             dr_val;
    logic [CNT_W-1:0]       wpos;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] s, input logic taken);
        if (taken) begin
            return (s == 2'b11) ? s : s + 2'd1;
        end else begin
            return (s == 2'b00) ? s : s - 2'd1;
        end
    endfunction

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    assign hist = ghr_q;
`else
    assign hist = '0;
`endif

    assign run  = (state_q == S_RUN);
    assign full = (cnt_q == CNT_W'(UPDQ_D));

    // A full FIFO takes the slot even with a lookup pending. Otherwise
    // lookups win and updates drain only in idle slots.
    assign drain  = run && (cnt_q != '0) && (!lk_valid || full);
    assign lookup = run && lk_valid && !drain;

    assign lk_ready = run && !full;
    assign up_ready = run && !full;
    assign push     = up_valid && up_ready;

    // FIFO stores the raw PC index. History is applied at drain time.
    assign lk_idx = lk_pc[IDX_W+1:2] ^ hist;
    assign dr_idx = fifo_idx_q[0] ^ hist;
    assign dr_val = sat_step(tbl_q[dr_idx], fifo_tk_q[0]);

    // On a simultaneous pop, the new entry lands one slot lower.
    assign wpos = drain ? (cnt_q - CNT_W'(1)) : cnt_q;

    assign pred_valid = pred_valid_q;
    assign pred_state = pred_state_q;
    assign pred_taken = pred_state_q[1];
    assign init_busy  = init_busy_q;

    // Control state, FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            ptr_q        <= '0;
            init_busy_q  <= 1'b1;
            cnt_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_state_q <= 2'b00;
`ifdef BHT_GSHARE_EN
            ghr_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_INIT: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                        state_q     <= S_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase

            case ({push, drain})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase

            pred_valid_q <= lookup;
            if (lookup) begin
                pred_state_q <= tbl_q[lk_idx];
            end

`ifdef BHT_GSHARE_EN
            // The truncating cast drops the oldest bit. It also covers IDX_W == 1.
            if (drain) begin
                ghr_q <= IDX_W'({ghr_q, fifo_tk_q[0]});
            end
`endif
        end
    end

    // Counter table: sweep write during INIT, drain write during RUN
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            tbl_q[ptr_q] <= 2'b00;
        end else if (drain) begin
            tbl_q[dr_idx] <= dr_val;
        end
    end

    // Update FIFO storage. Head is slot 0 and shifts down on pop.
    // The push assignment comes last, so it overrides the shift for the slot it writes.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int i = 0; i < UPDQ_D - 1; i++) begin
                fifo_idx_q[i] <= fifo_idx_q[i+1];
                fifo_tk_q[i]  <= fifo_tk_q[i+1];
            end
        end
        for (int i = 0; i < UPDQ_D; i++) begin
            if (push && (wpos == CNT_W'(i))) begin
                fifo_idx_q[i] <= up_pc[IDX_W+1:2];
                fifo_tk_q[i]  <= up_taken;
            end
        end
    end

    // PC bits outside the index field are intentionally not used.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0]};

endmodule

// File: tb/tb_bht_ctrl.sv
module tb_bht_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        lk_ready;
    logic        pred_valid;
    logic [1:0]  pred_state;
    logic        pred_taken;
    logic        up_valid = 1'b0;
    logic [31:0] up_pc = '0;
    logic        up_taken = 1'b0;
    logic        up_ready;
    logic        init_busy;

    int tests = 0;
    int fails = 0;
    logic [1:0] exp_q[$];

    bht_ctrl #(.IDX_W(6), .UPDQ_D(2)) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_state(pred_state), .pred_taken(pred_taken),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single accepted lookup; expected counter is queued for the monitor.
    task automatic lookup(input logic [31:0] pc, input logic [1:0] exp);
        lk_valid = 1'b1;
        lk_pc    = pc;
        chk("lk_ready", {31'd0, lk_ready}, 32'd1);
        if (lk_ready) exp_q.push_back(exp);
        tick();
        lk_valid = 1'b0;
        tick();
    endtask

    // Single update, then idle slots so it drains before the next step.
    task automatic upd(input logic [31:0] pc, input logic tk);
        int n;
        up_valid = 1'b1;
        up_pc    = pc;
        up_taken = tk;
        n = 0;
        while (!up_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("up_ready_timeout", 32'd0, 32'd1);
        tick();
        up_valid = 1'b0;
        tick(2);
    endtask

    task automatic sweep_check(input string tag);
        int n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        while (init_busy === 1'b1 && n < 200) begin
            if (lk_ready !== 1'b0 || up_ready !== 1'b0) bad = 1'b1;
            n++;
            tick();
        end
        chk({tag, "_len"}, n, 64);
        chk({tag, "_ready_low"}, {31'd0, bad}, 32'd0);
    endtask

    // Scoreboard: every prediction must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && pred_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pred_valid", 32'd1, 32'd0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("pred_state", {30'd0, pred_state}, {30'd0, e});
                chk("pred_taken", {31'd0, pred_taken}, {31'd0, e[1]});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, sweep, first lookup
        #1 rst = 1'b1;
        tick(3);
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_lk_ready", {31'd0, lk_ready}, 32'd0);
        chk("rst_up_ready", {31'd0, up_ready}, 32'd0);
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_state", {30'd0, pred_state}, 32'd0);
        rst = 1'b0;
        // Traffic during the sweep must be ignored.
        lk_valid = 1'b1; lk_pc = 32'h40;
        up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1;
        sweep_check("sweep1");
        lk_valid = 1'b0; up_valid = 1'b0;
        lookup(32'h40, 2'b00);

        // 2: training
        repeat (3) upd(32'h40, 1'b1);
        lookup(32'h40, 2'b11);
        upd(32'h40, 1'b0);
        lookup(32'h40, 2'b10);

        // 3: saturation
        repeat (4) upd(32'h80, 1'b0);
        lookup(32'h80, 2'b00);
        repeat (5) upd(32'h80, 1'b1);
        lookup(32'h80, 2'b11);

        // 4: contention with lk_valid held high
        lk_valid = 1'b1; lk_pc = 32'h200;
        up_valid = 1'b1; up_pc = 32'h0C; up_taken = 1'b1;
        chk("c0_lk_ready", {31'd0, lk_ready}, 32'd1);
        exp_q.push_back(2'b00);
        tick();
        chk("c1_lk_ready", {31'd0, lk_ready}, 32'd1);
        chk("c1_up_ready", {31'd0, up_ready}, 32'd1);
        exp_q.push_back(2'b00);
        tick();
        chk("c2_lk_ready", {31'd0, lk_ready}, 32'd0);
        chk("c2_up_ready", {31'd0, up_ready}, 32'd0);
        up_valid = 1'b0;
        tick();
        chk("c3_lk_ready", {31'd0, lk_ready}, 32'd1);
        lk_valid = 1'b0;
        tick();
        chk("c4_up_ready", {31'd0, up_ready}, 32'd1);
        lookup(32'h0C, 2'b10);

        // 5: aliasing (0x40 and 0x140 share index 16)
        upd(32'h40, 1'b1);
        lookup(32'h140, 2'b11);

        // 6: reset mid-cycle with a full FIFO
        lk_valid = 1'b1; lk_pc = 32'h200;
        up_valid = 1'b1; up_pc = 32'h0C; up_taken = 1'b0;
        exp_q.push_back(2'b00);
        tick();
        exp_q.push_back(2'b00);
        tick();
        chk("r_full_lk_ready", {31'd0, lk_ready}, 32'd0);
        up_valid = 1'b0; lk_valid = 1'b0;
        #6 rst = 1'b1;
        #1;
        chk("r_init_busy", {31'd0, init_busy}, 32'd1);
        chk("r_lk_ready", {31'd0, lk_ready}, 32'd0);
        chk("r_up_ready", {31'd0, up_ready}, 32'd0);
        chk("r_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("r_pred_state", {30'd0, pred_state}, 32'd0);
        tick(2);
        rst = 1'b0;
        sweep_check("sweep2");
        chk("post_lk_ready", {31'd0, lk_ready}, 32'd1);
        chk("post_up_ready", {31'd0, up_ready}, 32'd1);
        lk_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            lk_pc = 32'(i) << 2;
            chk("all_lk_ready", {31'd0, lk_ready}, 32'd1);
            if (lk_ready) exp_q.push_back(2'b00);
            tick();
        end
        lk_valid = 1'b0;
        tick(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
